// File: rtl/uart_rx_frame_ctrl.sv
// rtl/uart_rx_frame_ctrl.sv - assembles SYNC/OP/LEN/payload/CSUM byte frames from uart_rx into validated commands
module uart_rx_frame_ctrl #(
    parameter int         MAX_LEN       = 8,
    parameter logic [7:0] SYNC          = 8'hAA,
    parameter int         TIMEOUT_TICKS = 640
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   rx_done_tick,
    input  logic [7:0]             rx_data,
    input  logic                   s_tick,
    output logic                   cmd_valid,
    input  logic                   cmd_ready,
    output logic [7:0]             cmd_op,
    output logic [3:0]             cmd_len,
    output logic [8*MAX_LEN-1:0]   cmd_payload,
    output logic                   err_tick,
    output logic [1:0]             err_code
);

    localparam int                CNT_W     = $clog2(TIMEOUT_TICKS);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(TIMEOUT_TICKS - 1);
    localparam logic [7:0]        MAX_LEN_B = 8'(MAX_LEN);

    localparam logic [2:0] ST_HUNT    = 3'd0;
    localparam logic [2:0] ST_OP      = 3'd1;
    localparam logic [2:0] ST_LEN     = 3'd2;
    localparam logic [2:0] ST_PAYLOAD = 3'd3;
    localparam logic [2:0] ST_CSUM    = 3'd4;
    localparam logic [2:0] ST_HOLD    = 3'd5;

    localparam logic [1:0] ERR_OVERRUN = 2'b00;
    localparam logic [1:0] ERR_CSUM    = 2'b01;
    localparam logic [1:0] ERR_LEN     = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT = 2'b11;

    logic [2:0]             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [3:0]             idx_q, idx_d;
    logic [7:0]             xor_q, xor_d;
    logic                   valid_q, valid_d;
    logic [7:0]             op_q, op_d;
    logic [3:0]             len_q, len_d;
    logic [8*MAX_LEN-1:0]   payload_q, payload_d;
    logic                   err_tick_q, err_tick_d;
    logic [1:0]             err_code_q, err_code_d;
    logic                   in_frame;

    assign in_frame = (state_q == ST_OP) || (state_q == ST_LEN) ||
                      (state_q == ST_PAYLOAD) || (state_q == ST_CSUM);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        xor_d      = xor_q;
        valid_d    = valid_q;
        op_d       = op_q;
        len_d      = len_q;
        payload_d  = payload_q;
        err_tick_d = 1'b0;
        err_code_d = err_code_q;

        case (state_q)
            ST_HUNT: begin
                if (rx_done_tick && rx_data == SYNC) begin
                    state_d = ST_OP;
                end
            end
            ST_OP: begin
                if (rx_done_tick) begin
                    op_d      = rx_data;
                    xor_d     = rx_data;
                    payload_d = '0;
                    state_d   = ST_LEN;
                end
            end
            ST_LEN: begin
                if (rx_done_tick) begin
                    xor_d = xor_q ^ rx_data;
                    if (rx_data > MAX_LEN_B) begin
                        err_tick_d = 1'b1;
                        err_code_d = ERR_LEN;
                        state_d    = ST_HUNT;
                    end else begin
                        len_d   = rx_data[3:0];
                        idx_d   = 4'd0;
                        state_d = (rx_data == 8'd0) ? ST_CSUM : ST_PAYLOAD;
                    end
                end
            end
            ST_PAYLOAD: begin
                if (rx_done_tick) begin
                    for (int i = 0; i < MAX_LEN; i++) begin
                        if (idx_q == 4'(i)) begin
                            payload_d[8*i +: 8] = rx_data;
                        end
                    end
                    xor_d = xor_q ^ rx_data;
                    if (idx_q == len_q - 4'd1) begin
                        state_d = ST_CSUM;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            ST_CSUM: begin
                if (rx_done_tick) begin
                    if (rx_data == xor_q) begin
                        valid_d = 1'b1;
                        state_d = ST_HOLD;
                    end else begin
                        err_tick_d = 1'b1;
                        err_code_d = ERR_CSUM;
                        state_d    = ST_HUNT;
                    end
                end
            end
            ST_HOLD: begin
                // Acceptance and an overrun byte in the same cycle are independent: both happen.
                if (cmd_ready) begin
                    valid_d = 1'b0;
                    state_d = ST_HUNT;
                end
                if (rx_done_tick) begin
                    err_tick_d = 1'b1;
                    err_code_d = ERR_OVERRUN;
                end
            end
            default: begin
                state_d = ST_HUNT;
            end
        endcase

        // A received byte always wins over an expiring tick, so timeout only acts without rx_done_tick.
        if (!in_frame || rx_done_tick) begin
            cnt_d = '0;
        end else if (s_tick) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d      = '0;
                err_tick_d = 1'b1;
                err_code_d = ERR_TIMEOUT;
                state_d    = ST_HUNT;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_HUNT;
            cnt_q      <= '0;
            idx_q      <= 4'd0;
            xor_q      <= 8'd0;
            valid_q    <= 1'b0;
            op_q       <= 8'd0;
            len_q      <= 4'd0;
            payload_q  <= '0;
            err_tick_q <= 1'b0;
            err_code_q <= 2'b00;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            xor_q      <= xor_d;
            valid_q    <= valid_d;
            op_q       <= op_d;
            len_q      <= len_d;
            payload_q  <= payload_d;
            err_tick_q <= err_tick_d;
            err_code_q <= err_code_d;
        end
    end

    assign cmd_valid   = valid_q;
    assign cmd_op      = op_q;
    assign cmd_len     = len_q;
    assign cmd_payload = payload_q;
    assign err_tick    = err_tick_q;
    assign err_code    = err_code_q;

endmodule
